// File: rtl/wb_port_arbiter_if.sv
// Multi-cycle result channel into the writeback port arbiter.
// valid/ready: a result transfers on a cycle where valid && ready. Once valid is raised,
// rd_addr and data stay stable until that transfer. ready never depends on valid.
interface wb_port_arbiter_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH     = 32
) ();
  logic                      valid;
  logic                      ready;
  logic [REG_ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0]     data;

  modport master (output valid, output rd_addr, output data, input ready);
  modport slave  (input valid, input rd_addr, input data, output ready);
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback first, multi-cycle results buffered in order.
// Optional WB_ARB_PERF_EN adds perf_stall_cnt_o, a saturating count of stall_pipe_o cycles.
module wb_port_arbiter #(
  parameter int DEPTH          = 2,
  parameter int STARVE_LIMIT   = 4,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  wb_port_arbiter_if.slave          mc,
  input  logic                      reg_write_wb_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_wb_i,
  input  logic [DATA_WIDTH-1:0]     result_wb_i,
  output logic                      rf_we_o,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [DATA_WIDTH-1:0]     rf_wdata_o,
  output logic                      stall_pipe_o,
  input  logic [REG_ADDR_WIDTH-1:0] chk_rd_i,
  output logic                      chk_pend_o,
  output logic [1:0]                dbg_state_o
`ifdef WB_ARB_PERF_EN
  ,
  output logic [31:0]               perf_stall_cnt_o
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                    state, state_nxt;
  logic [CW-1:0]             count, count_nxt;
  logic [WW-1:0]             wait_cnt, wait_nxt;
  logic [PW-1:0]             rd_ptr, wr_ptr;
  logic [DEPTH-1:0]          buf_vld;
  logic [REG_ADDR_WIDTH-1:0] buf_rd   [DEPTH];
  logic [DATA_WIDTH-1:0]     buf_data [DEPTH];

  logic buf_empty, xfer, pipe_we, head_grant, bypass, enq;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Ready looks only at registered state so a dequeue cannot open a slot in the same cycle.
  assign buf_empty  = (count == '0);
  assign mc.ready   = rst_n && (count < CW'(DEPTH)) && (state != ST_DRAIN);
  assign xfer       = mc.valid && mc.ready;
  assign pipe_we    = rst_n && reg_write_wb_i && (rd_addr_wb_i != '0);
  assign head_grant = rst_n && !pipe_we && !buf_empty;
  assign bypass     = !pipe_we && buf_empty && xfer && (mc.rd_addr != '0);
  assign enq        = xfer && (mc.rd_addr != '0) && !bypass;

  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    if (pipe_we) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = rd_addr_wb_i;
      rf_wdata_o = result_wb_i;
    end else if (head_grant) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = buf_rd[rd_ptr];
      rf_wdata_o = buf_data[rd_ptr];
    end else if (bypass) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = mc.rd_addr;
      rf_wdata_o = mc.data;
    end
  end

  always_comb begin
    count_nxt = count;
    if (enq && !head_grant)      count_nxt = count + CW'(1);
    else if (!enq && head_grant) count_nxt = count - CW'(1);
  end

  always_comb begin
    wait_nxt = '0;
    if (!buf_empty && !head_grant)
      wait_nxt = (wait_cnt == WW'(STARVE_LIMIT)) ? wait_cnt : wait_cnt + WW'(1);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (count_nxt != '0) state_nxt = ST_PEND;
      ST_PEND: begin
        if (count_nxt == '0)                     state_nxt = ST_IDLE;
        else if (wait_nxt == WW'(STARVE_LIMIT))  state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (count_nxt == '0) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      count    <= '0;
      wait_cnt <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      buf_vld  <= '0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      wait_cnt <= wait_nxt;
      if (enq) begin
        buf_vld[wr_ptr] <= 1'b1;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (head_grant) begin
        buf_vld[rd_ptr] <= 1'b0;
        rd_ptr          <= ptr_inc(rd_ptr);
      end
    end
  end

  // Payload needs no reset; buf_vld alone says which slots are meaningful.
  always_ff @(posedge clk) begin
    if (enq) begin
      buf_rd[wr_ptr]   <= mc.rd_addr;
      buf_data[wr_ptr] <= mc.data;
    end
  end

  always_comb begin
    chk_pend_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (buf_vld[i] && (buf_rd[i] == chk_rd_i)) chk_pend_o = 1'b1;
    end
    if (chk_rd_i == '0) chk_pend_o = 1'b0;
  end

  assign stall_pipe_o = (state == ST_DRAIN);
  assign dbg_state_o  = state;

`ifdef WB_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      perf_stall_cnt_o <= '0;
    else if (stall_pipe_o && (perf_stall_cnt_o != '1)) perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
  end
`endif

endmodule
